// File: rtl/seq_stream_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : seq_stream_pkg                                            |
// | Description : Shared types and constants for the sequence-detector      |
// |               stream controller (state encoding, hit-total width,       |
// |               hit-count width helper).                                  |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package seq_stream_pkg;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CLR   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Width of the cumulative hit counter (optional total_hits output)
  localparam int TOTAL_W = 16;

  // Bits needed to count from 0 up to and including width hits
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_stream_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : seq_stream_ctrl_if                                        |
// | Description : Word handshake, result and detector-side signals of the   |
// |               stream controller. slave = controller view, master =      |
// |               producer plus detector view. total_hits exists only when  |
// |               SEQ_STREAM_CTRL_TOTAL_EN is defined.                      |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
interface seq_stream_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = seq_stream_pkg::cnt_width(WIDTH)
);
  import seq_stream_pkg::*;

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             clear_det;
  logic             word_ready;
  logic             det_reset;
  logic             det_in;
  logic             det_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hit_mask;
  logic [CNT_W-1:0] hit_count;
`ifdef SEQ_STREAM_CTRL_TOTAL_EN
  logic [TOTAL_W-1:0] total_hits;

  modport slave (
    input  word_in, word_valid, clear_det, det_out,
    output word_ready, det_reset, det_in, busy, done, hit_mask, hit_count, total_hits
  );
  modport master (
    output word_in, word_valid, clear_det, det_out,
    input  word_ready, det_reset, det_in, busy, done, hit_mask, hit_count, total_hits
  );
`else
  modport slave (
    input  word_in, word_valid, clear_det, det_out,
    output word_ready, det_reset, det_in, busy, done, hit_mask, hit_count
  );
  modport master (
    output word_in, word_valid, clear_det, det_out,
    input  word_ready, det_reset, det_in, busy, done, hit_mask, hit_count
  );
`endif

endinterface
`default_nettype wire

// File: rtl/seq_stream_ctrl_piso.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seq_piso                                                  |
// | Description : WIDTH-bit load / shift-left register, serial MSB out.     |
// |               Zeros shift in from the LSB so the output idles low once  |
// |               the loaded word has been emitted.                         |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module seq_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_sreg;

  // Load wins over shift; shifting moves the next bit into the MSB position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_din;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign o_sout = r_sreg[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/seq_stream_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : seq_stream_ctrl                                           |
// | Description : Accepts words over valid/ready, optionally resets an      |
// |               external Moore sequence detector, streams each word       |
// |               MSB-first into it and collects the per-bit hit mask,      |
// |               hit count and a done pulse.                               |
// |               Optional: SEQ_STREAM_CTRL_TOTAL_EN adds a saturating      |
// |               16-bit cumulative hit total.                              |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  seq_stream_ctrl_if.slave   bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic             r_word_ready;
  logic             r_det_reset;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hit_mask;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_bitcnt;

  logic             w_accept;
  logic             w_piso_load;
  logic             w_piso_shift;
  logic [WIDTH-1:0] w_piso_data;
  logic             w_piso_sout;

  // word_ready is registered high exactly in IDLE, so the accept needs only the state
  assign w_accept     = (r_state == ST_IDLE) && bus.word_valid;
  // Without a detector clear the word is loaded straight away; with one it is
  // loaded while the detector sits in reset so det_in stays low during CLR.
  assign w_piso_load  = (w_accept && !bus.clear_det) || (r_state == ST_CLR);
  assign w_piso_data  = (r_state == ST_CLR) ? r_word : bus.word_in;
  assign w_piso_shift = (r_state == ST_SHIFT);

  seq_piso #(
    .WIDTH   (WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (reset),
    .i_load  (w_piso_load),
    .i_shift (w_piso_shift),
    .i_din   (w_piso_data),
    .o_sout  (w_piso_sout)
  );

  // Sequencer: walks the word through the detector and shifts each Moore
  // result (one cycle behind its input bit) into the mask from the LSB side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_word       <= '0;
      r_word_ready <= 1'b0;
      r_det_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hit_mask   <= '0;
      r_hit_count  <= '0;
      r_bitcnt     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_det_reset  <= 1'b0;
          r_word_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.word_valid) begin
            r_word       <= bus.word_in;
            r_hit_mask   <= '0;
            r_hit_count  <= '0;
            r_bitcnt     <= '0;
            r_busy       <= 1'b1;
            r_word_ready <= 1'b0;
            if (bus.clear_det) begin
              r_det_reset <= 1'b1;
              r_state     <= ST_CLR;
            end else begin
              r_state     <= ST_SHIFT;
            end
          end
        end
        ST_CLR: begin
          r_det_reset <= 1'b0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Cycle 0 has no result yet; later cycles see the previous bit's output
          if (r_bitcnt != '0) begin
            r_hit_mask  <= {r_hit_mask[WIDTH-2:0], bus.det_out};
            r_hit_count <= r_hit_count + CNT_W'(bus.det_out);
          end
          if (r_bitcnt == CNT_W'(WIDTH - 1)) begin
            r_state <= ST_DRAIN;
          end
          r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
        ST_DRAIN: begin
          r_hit_mask  <= {r_hit_mask[WIDTH-2:0], bus.det_out};
          r_hit_count <= r_hit_count + CNT_W'(bus.det_out);
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          r_done       <= 1'b0;
          r_word_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_det_reset  <= 1'b1;
          r_word_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.word_ready = r_word_ready;
  assign bus.det_reset  = r_det_reset;
  assign bus.det_in     = w_piso_sout;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.hit_mask   = r_hit_mask;
  assign bus.hit_count  = r_hit_count;

`ifdef SEQ_STREAM_CTRL_TOTAL_EN
  logic [TOTAL_W-1:0] r_total;
  logic [TOTAL_W:0]   w_total_sum;

  // One spare bit catches the carry that signals saturation
  assign w_total_sum = {1'b0, r_total} + (TOTAL_W + 1)'(r_hit_count);

  // Accumulate the finished word's count while its done pulse is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_total <= '0;
    end else if (r_state == ST_DONE) begin
      r_total <= w_total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_total_sum[TOTAL_W-1:0];
    end
  end

  assign bus.total_hits = r_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_seq_stream_ctrl                                        |
// | Description : Self-checking bench for seq_stream_ctrl with an           |
// |               overlapping "1011" Moore detector, WIDTH=8.               |
// |               SEQ_STREAM_CTRL_TOTAL_EN enables the total_hits section.  |
// | Revision    : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module tb_seq_stream_ctrl;
  import seq_stream_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = cnt_width(WIDTH);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  seq_stream_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_stream_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External detector: Moore, output high when the last four inputs were 1,0,1,1
  logic [3:0] det_hist;
  always_ff @(posedge clk) begin
    if (bus.det_reset) det_hist <= '0;
    else               det_hist <= {det_hist[2:0], bus.det_in};
  end
  assign bus.det_out = (det_hist == 4'b1011);

  // ---------------- reference model ----------------
  // Bits the detector has seen since its last reset. Between two words at
  // least three zeros reach it (DRAIN, DONE, the accepting IDLE cycle); for a
  // "1011" pattern any run of three or more zeros has the same effect.
  bit model_stream[$];
  int model_total = 0;

  function automatic void model_word(input logic [WIDTH-1:0] word, input logic clr,
                                     output logic [WIDTH-1:0] mask, output int cnt);
    int n;
    if (clr) model_stream.delete();
    else repeat (3) model_stream.push_back(1'b0);
    mask = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      model_stream.push_back(word[j]);
      n = model_stream.size();
      if (n >= 4 && model_stream[n-4] == 1'b1 && model_stream[n-3] == 1'b0 &&
          model_stream[n-2] == 1'b1 && model_stream[n-1] == 1'b1)
        mask[j] = 1'b1;
    end
    cnt = $countones(mask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endtask

  // Called at a negedge. Sends one word, follows it to done, checks protocol
  // details and returns the DUT results plus the model's expectation.
  task automatic send_word(input logic [WIDTH-1:0] word, input logic clr,
                           input bit hold, input bit noise,
                           output logic [WIDTH-1:0] act_mask, output int act_cnt,
                           output int act_lat,
                           output logic [WIDTH-1:0] exp_mask, output int exp_cnt);
    int          wait_cnt;
    int          lat;
    logic [31:0] seq;
    bit          ready_ok;
    bit          busy_ok;
    bit          got_done;
    act_mask = '0; act_cnt = -1; act_lat = -1; exp_mask = '0; exp_cnt = 0;
    bus.word_in    = word;
    bus.clear_det  = clr;
    bus.word_valid = 1'b1;
    wait_cnt = 0;
    while (!bus.word_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus.word_ready) begin
      fail_now("accept_wait");
      bus.word_valid = 1'b0;
      return;
    end
    model_word(word, clr, exp_mask, exp_cnt);
    @(posedge clk);
    @(negedge clk);
    if (clr) check("clr_det_reset", 32'(bus.det_reset), 32'd1);
    if (!hold) begin
      bus.word_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) bus.word_in = WIDTH'($urandom);
    end
    seq      = {31'b0, bus.det_in};
    ready_ok = !bus.word_ready;
    busy_ok  = bus.busy;
    lat      = 0;
    got_done = 0;
    while (!got_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.word_ready) ready_ok = 0;
      if (bus.done) begin
        got_done = 1;
        if (!hold) bus.word_valid = 1'b0;
      end else begin
        seq = {seq[30:0], bus.det_in};
        if (!bus.busy) busy_ok = 0;
        if (noise && !hold) begin
          bus.word_valid = 1'($urandom_range(0, 1));
          bus.word_in    = WIDTH'($urandom);
        end
      end
    end
    if (!got_done) begin
      fail_now("done_wait");
      bus.word_valid = 1'b0;
      return;
    end
    act_lat  = lat;
    act_mask = bus.hit_mask;
    act_cnt  = int'(bus.hit_count);
    check("det_in_seq", seq, 32'({word, 1'b0}));
    check("ready_low_while_busy", 32'(ready_ok), 32'd1);
    check("busy_high_in_word", 32'(busy_ok), 32'd1);
    // One cycle later: done gone, ready back, results still held
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("ready_after_done", 32'(bus.word_ready), 32'd1);
    check("mask_holds", 32'(bus.hit_mask), 32'(act_mask));
    model_total = (model_total + exp_cnt > 65535) ? 65535 : model_total + exp_cnt;
    bus.word_valid = hold;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [WIDTH-1:0] word;
    logic             clr;
    logic [WIDTH-1:0] mask;
    int               cnt;
    int               lat;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [WIDTH-1:0] am, em;
    logic [WIDTH-1:0] w;
    logic             c;
    int               ac, al, ec;

    // Hand-derived expectations for the "1011" detector
    vecs[0] = '{8'b1011_0110, 1'b1, 8'h12, 2, WIDTH + 2};
    vecs[1] = '{8'h01,        1'b1, 8'h00, 0, WIDTH + 2};
    vecs[2] = '{8'b0110_0000, 1'b0, 8'h00, 0, WIDTH + 1}; // idle zeros separate the words
    vecs[3] = '{8'b0110_0000, 1'b1, 8'h00, 0, WIDTH + 2};
    vecs[4] = '{8'h0B,        1'b1, 8'h01, 1, WIDTH + 2};
    vecs[5] = '{8'h2D,        1'b0, 8'h04, 1, WIDTH + 1};
    vecs[6] = '{8'hB5,        1'b1, 8'h10, 1, WIDTH + 2};
    vecs[7] = '{8'h5B,        1'b0, 8'h09, 2, WIDTH + 1};
    vecs[8] = '{8'hFF,        1'b1, 8'h00, 0, WIDTH + 2};

    bus.word_in = '0; bus.word_valid = 1'b0; bus.clear_det = 1'b0;

    // Reset values while reset is held, then the INIT cycle and IDLE
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_det_reset", 32'(bus.det_reset), 32'd1);
    check("rst_word_ready", 32'(bus.word_ready), 32'd0);
    check("rst_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
    check("rst_hit_count", 32'(bus.hit_count), 32'd0);
    check("rst_hit_mask", 32'(bus.hit_mask), 32'd0);
    check("rst_det_in", 32'(bus.det_in), 32'd0);
    reset = 1'b0;
    #1;
    check("init_det_reset", 32'(bus.det_reset), 32'd1);
    check("init_word_ready", 32'(bus.word_ready), 32'd0);
    @(negedge clk);
    check("idle_word_ready", 32'(bus.word_ready), 32'd1);
    check("idle_det_reset", 32'(bus.det_reset), 32'd0);

    // Table: back-to-back words against hand-computed results
    for (int i = 0; i < 9; i++) begin
      send_word(vecs[i].word, vecs[i].clr, 1'b0, 1'b0, am, ac, al, em, ec);
      check($sformatf("vec%0d_mask", i), 32'(am), 32'(vecs[i].mask));
      check($sformatf("vec%0d_count", i), 32'(ac), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_latency", i), 32'(al), 32'(vecs[i].lat));
    end

    // word_valid held high across alternating words: one result per word
    for (int i = 0; i < 4; i++) begin
      w = (i % 2 == 0) ? 8'hB6 : 8'h5B;
      c = 1'(i % 2 == 0);
      send_word(w, c, 1'b1, 1'b0, am, ac, al, em, ec);
      check($sformatf("hold%0d_mask", i), 32'(am), 32'(em));
      check($sformatf("hold%0d_count", i), 32'(ac), 32'(ec));
    end
    bus.word_valid = 1'b0;
    @(negedge clk);

    // Reset during SHIFT cycle 4 aborts the word
    bus.word_in = 8'hB6; bus.clear_det = 1'b1; bus.word_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.word_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hit_count", 32'(bus.hit_count), 32'd0);
    check("abort_hit_mask", 32'(bus.hit_mask), 32'd0);
    check("abort_det_reset", 32'(bus.det_reset), 32'd1);
    check("abort_det_in", 32'(bus.det_in), 32'd0);
    model_stream.delete();
    model_total = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_release_det_reset", 32'(bus.det_reset), 32'd1);
    @(negedge clk);
    send_word(8'h0B, 1'b0, 1'b0, 1'b0, am, ac, al, em, ec);
    check("post_abort_mask", 32'(am), 32'h01);
    check("post_abort_count", 32'(ac), 32'd1);

    // Randomized words, gaps and ignored valid noise against the model
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = WIDTH'($urandom);
      if ($urandom_range(0, 2) == 0) w = 8'h0B | WIDTH'($urandom_range(0, 255) & 8'hB0);
      c = 1'($urandom_range(0, 1));
      send_word(w, c, 1'b0, 1'($urandom_range(0, 1)), am, ac, al, em, ec);
      check($sformatf("rnd%0d_mask w=%0h", i, w), 32'(am), 32'(em));
      check($sformatf("rnd%0d_count", i), 32'(ac), 32'(ec));
      check($sformatf("rnd%0d_latency", i), 32'(al), c ? 32'(WIDTH + 2) : 32'(WIDTH + 1));
    end

`ifdef SEQ_STREAM_CTRL_TOTAL_EN
    check("total_running", 32'(bus.total_hits), 32'(model_total));
    force dut.r_total = 16'hFFF0;
    @(negedge clk);
    release dut.r_total;
    model_total = 32'hFFF0;
    for (int i = 0; i < 10; i++) begin
      send_word(8'h5B, 1'b1, 1'b0, 1'b0, am, ac, al, em, ec);
    end
    check("total_saturated", 32'(bus.total_hits), 32'hFFFF);
    check("total_model", 32'(bus.total_hits), 32'(model_total));
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
